// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_t;

  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned DEF_LINE_W = 256;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_LINES  = 16;

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned num_lines);
    return addr_w - OFFSET_W - $clog2(num_lines);
  endfunction

  localparam int unsigned DEF_TAG_W = tag_w(DEF_ADDR_W, DEF_LINES);

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, synchronous line or word write,
// asynchronous clear of valid/dirty so a reset invalidates every line at once.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_LINES,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned LINE_W    = DEF_LINE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]           word_data
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[wr_idx] <= line_data;
      tag_q[wr_idx]  <= line_tag;
    end else if (word_we) begin
      data_q[wr_idx][32*int'(word_sel) +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache with stall-on-miss.
// Define DCACHE_STATS_EN to add saturating hit_cnt_o / miss_cnt_o counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_LINES,
  parameter int unsigned LINE_W    = DEF_LINE_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, NUM_LINES);

  state_t                state;
  logic [IDX_W-1:0]      cpu_idx, req_idx, wr_idx;
  logic [TAG_W-1:0]      cpu_tag, req_tag, rd_tag;
  logic [WORD_SEL_W-1:0] cpu_word;
  logic [LINE_W-1:0]     rd_line;
  logic                  rd_valid, rd_dirty;
  logic                  hit, miss, line_we, word_we;
  logic                  unused_addr;

  assign cpu_word    = cpu_addr_i[OFFSET_W-1:2];
  assign cpu_idx     = cpu_addr_i[OFFSET_W +: IDX_W];
  assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit         = cpu_req_i & rd_valid & (rd_tag == cpu_tag) & (state == IDLE);
  assign miss        = cpu_req_i & ~hit & (state == IDLE);
  assign cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
  assign cpu_data_o  = hit ? rd_line[32*int'(cpu_word) +: 32] : '0;

  // Refill uses the index latched at miss entry; word stores only happen on an IDLE hit.
  assign line_we = (state == ALLOCATE) & mem_ack_i;
  assign word_we = hit & cpu_we_i;
  assign wr_idx  = line_we ? req_idx : cpu_idx;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_sram (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .rd_idx    (cpu_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (wr_idx),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (cpu_word),
    .word_data (cpu_data_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      req_tag    <= '0;
      req_idx    <= '0;
    end else begin
      unique case (state)
        IDLE: if (miss) begin
          req_tag   <= cpu_tag;
          req_idx   <= cpu_idx;
          mem_req_o <= 1'b1;
          if (rd_valid && rd_dirty) begin
            state      <= WRITEBACK;
            mem_we_o   <= 1'b1;
            mem_addr_o <= {rd_tag, cpu_idx, {OFFSET_W{1'b0}}};
            mem_data_o <= rd_line;
          end else begin
            state      <= ALLOCATE;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          state      <= ALLOCATE;
          mem_we_o   <= 1'b0;
          mem_addr_o <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
        end
        ALLOCATE: if (mem_ack_i) begin
          state     <= REFILL;
          mem_req_o <= 1'b0;
        end
        REFILL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // retry marks the first IDLE cycle after a refill, whose hit is the replay of a miss.
  logic retry;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      retry      <= 1'b0;
    end else begin
      retry <= (state == REFILL);
      if (hit && !retry && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold fill, hit table, dirty eviction, reset abort.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  dcache_controller #(
    .NUM_LINES (16),
    .LINE_W    (256),
    .ADDR_W    (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t         vecs [10];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_hits = 0;
  int           stalls;
  logic         done, wb_seen;
  logic [31:0]  served, wb_addr, alloc_addr;
  logic [255:0] wb_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(w);
    return l;
  endfunction

  // Memory model: acks after lat cycles of mem_req_o; called just after inputs are driven.
  task automatic run_miss(input int lat, input logic [255:0] line);
    int cnt = 0;
    wb_seen = 1'b0; wb_addr = '0; wb_data = '0; alloc_addr = '0;
    stalls = 0; done = 1'b0; served = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!cpu_stall_o) begin
        done   = 1'b1;
        served = cpu_data_o;
      end else begin
        stalls++;
        if (mem_req_o) begin
          if (mem_we_o) begin
            wb_seen = 1'b1; wb_addr = mem_addr_o; wb_data = mem_data_o;
          end else begin
            alloc_addr = mem_addr_o;
          end
          cnt++;
          if (cnt == lat) begin
            mem_ack_i = 1'b1; mem_data_i = line; cnt = 0;
          end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
      end
    end
    check("miss_completed", 32'(done), 32'd1);
  endtask

  initial begin
    //            req   we    addr          wdata         ack   stall chk   data
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0010};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_005C, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0017};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0058, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0058, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0010};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0013};

    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 32'(cpu_stall_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_data_nz", 32'(|mem_data_o), 32'd0);
    check("rst_cpu_data", cpu_data_o, 32'h0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b1;

    // Cold read miss, 10-cycle memory: stall = 10 + 2
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040;
    run_miss(10, mk_line(32'h10));
    check("t1_stall_cycles", 32'(stalls), 32'd12);
    check("t1_load_data", served, 32'h0000_0010);
    check("t1_no_writeback", 32'(wb_seen), 32'd0);
    check("t1_alloc_addr", alloc_addr, 32'h0000_0040);
`ifdef DCACHE_STATS_EN
    check("t1_hit_cnt", hit_cnt_o, 32'd0);
    check("t1_miss_cnt", miss_cnt_o, 32'd1);
`endif

    // Hit table on line 2, including a stray ack while idle
    foreach (vecs[i]) begin
      @(negedge clk);
      cpu_req_i = vecs[i].req; cpu_we_i = vecs[i].we; cpu_addr_i = vecs[i].addr;
      cpu_data_i = vecs[i].wdata; mem_ack_i = vecs[i].ack; mem_data_i = mk_line(32'h99);
      if (vecs[i].req) exp_hits++;
      #1;
      check($sformatf("vec%0d_stall", i), 32'(cpu_stall_o), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_mem_req", i), 32'(mem_req_o), 32'd0);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), cpu_data_o, vecs[i].exp_data);
    end
    mem_ack_i = 1'b0;

    // Conflict miss on dirty line 2: write-back then allocate
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0240;
    run_miss(3, mk_line(32'h20));
    check("t3_stall_cycles", 32'(stalls), 32'd8);
    check("t3_load_data", served, 32'h0000_0020);
    check("t3_writeback_seen", 32'(wb_seen), 32'd1);
    check("t3_wb_addr", wb_addr, 32'h0000_0040);
    check("t3_wb_word0", wb_data[31:0], 32'h0000_0010);
    check("t3_wb_word1", wb_data[63:32], 32'hDEAD_BEEF);
    check("t3_wb_word6", wb_data[223:192], 32'h1234_5678);
    check("t3_alloc_addr", alloc_addr, 32'h0000_0240);
`ifdef DCACHE_STATS_EN
    check("t6_hit_cnt", hit_cnt_o, 32'(exp_hits));
    check("t6_miss_cnt", miss_cnt_o, 32'd2);
`endif

    // Reset during ALLOCATE, then a late ack
    @(negedge clk);
    cpu_addr_i = 32'h0000_0060;
    repeat (3) @(negedge clk);
    #1;
    check("t4_in_allocate_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("t4_abort_mem_req", 32'(mem_req_o), 32'd0);
    check("t4_abort_mem_addr", mem_addr_o, 32'h0);
    cpu_req_i = 1'b0;
    #1;
    check("t4_abort_stall", 32'(cpu_stall_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = mk_line(32'h99);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("t4_late_ack_mem_req", 32'(mem_req_o), 32'd0);
    check("t4_late_ack_stall", 32'(cpu_stall_o), 32'd0);
`ifdef DCACHE_STATS_EN
    check("t4_hit_cnt_cleared", hit_cnt_o, 32'd0);
    check("t4_miss_cnt_cleared", miss_cnt_o, 32'd0);
`endif
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040;
    #1;
    check("t4_reload_misses", 32'(cpu_stall_o), 32'd1);
    run_miss(2, mk_line(32'h30));
    check("t4_stall_cycles", 32'(stalls), 32'd4);
    check("t4_load_data", served, 32'h0000_0030);
    check("t4_no_writeback", 32'(wb_seen), 32'd0);
    check("t4_alloc_addr", alloc_addr, 32'h0000_0040);

    @(negedge clk);
    cpu_req_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
